// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load funct3 codes, writeback source selects
// and the canonical NOP instruction word.
package riscv_pkg;

  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  typedef enum logic [1:0] {
    WB_LD  = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  function automatic logic is_ctrl_op(input logic [6:0] opcode);
    return (opcode == OP_BR) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/mux_3_1.sv
// Three-input source selector; the fourth select code yields zero.
module mux_3_1 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half addressed by the low address
// bits and sign- or zero-extends it to XLEN according to funct3.
module wb_load_align #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [31:0]     raw_word,
  output logic [XLEN-1:0] data
);
  import riscv_pkg::*;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halfword selection looks only at offset[1]; misaligned halves are not split.
  always_comb begin
    sel_byte = raw_word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
  end

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = XLEN'($signed(sel_byte));
      F3_LBU:  data = XLEN'(sel_byte);
      F3_LH:   data = XLEN'($signed(sel_half));
      F3_LHU:  data = XLEN'(sel_half);
      default: data = XLEN'($signed(raw_word));
    endcase
  end

endmodule

// File: rtl/writeback_stage_reg.sv
// MEM/WB pipeline register with load alignment, source select, x0 write suppression
// and control-flow flagging. Define WB_PERF_CNT_EN to build the retirement counters.
module writeback_stage_reg #(
  parameter int          XLEN     = 32,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_mem_valid,
  input  logic [31:0]      i_mem_inst,
  input  logic [XLEN-1:0]  i_mem_pc_add4,
  input  logic [XLEN-1:0]  i_mem_alu_data,
  input  logic [31:0]      i_mem_ld_data,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic             i_mem_rd_wren,
  input  logic             i_cnt_clr,
  output logic             o_wb_valid,
  output logic [XLEN-1:0]  o_wb_data_wb,
  output logic [4:0]       o_wb_rd_addr,
  output logic             o_wb_rd_wren,
  output logic             o_wb_ctrl,
  output logic [CNT_W-1:0] o_wb_instret,
  output logic [CNT_W-1:0] o_wb_ctrl_cnt
);
  import riscv_pkg::*;

  logic            wb_valid;
  logic [31:0]     wb_inst;
  logic [XLEN-1:0] wb_pc_add4;
  logic [XLEN-1:0] wb_alu_data;
  logic [31:0]     wb_ld_data;
  logic [1:0]      wb_sel;
  logic            wb_rd_wren;
  logic [XLEN-1:0] ld_aligned;

  // Flush only needs to kill the instruction; the data fields may keep stale values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb_valid    <= 1'b0;
      wb_inst     <= NOP_INST;
      wb_pc_add4  <= '0;
      wb_alu_data <= '0;
      wb_ld_data  <= '0;
      wb_sel      <= WB_ALU;
      wb_rd_wren  <= 1'b0;
    end else if (i_flush) begin
      wb_valid    <= 1'b0;
      wb_inst     <= NOP_INST;
      wb_rd_wren  <= 1'b0;
    end else if (!i_stall) begin
      wb_valid    <= i_mem_valid;
      wb_inst     <= i_mem_inst;
      wb_pc_add4  <= i_mem_pc_add4;
      wb_alu_data <= i_mem_alu_data;
      wb_ld_data  <= i_mem_ld_data;
      wb_sel      <= i_mem_wb_sel;
      wb_rd_wren  <= i_mem_rd_wren;
    end
  end

  wb_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3   (wb_inst[14:12]),
    .offset   (wb_alu_data[1:0]),
    .raw_word (wb_ld_data),
    .data     (ld_aligned)
  );

  mux_3_1 #(.W(XLEN)) u_wb_mux (
    .sel (wb_sel),
    .in0 (ld_aligned),
    .in1 (wb_alu_data),
    .in2 (wb_pc_add4),
    .out (o_wb_data_wb)
  );

  assign o_wb_valid   = wb_valid;
  assign o_wb_rd_addr = wb_inst[11:7];
  assign o_wb_rd_wren = wb_valid & wb_rd_wren & (|wb_inst[11:7]);
  assign o_wb_ctrl    = wb_valid & is_ctrl_op(wb_inst[6:0]);

  logic unused_inst_bits;
  assign unused_inst_bits = ^wb_inst[31:15];

`ifdef WB_PERF_CNT_EN
  logic             fresh;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] ctrl_cnt_q;

  // fresh marks the first cycle an instruction sits in WB so a stall cannot recount it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fresh      <= 1'b0;
      instret_q  <= '0;
      ctrl_cnt_q <= '0;
    end else begin
      fresh <= !i_flush && !i_stall && i_mem_valid;
      if (i_cnt_clr) begin
        instret_q  <= '0;
        ctrl_cnt_q <= '0;
      end else if (fresh) begin
        instret_q <= instret_q + 1'b1;
        if (o_wb_ctrl)
          ctrl_cnt_q <= ctrl_cnt_q + 1'b1;
      end
    end
  end

  assign o_wb_instret  = instret_q;
  assign o_wb_ctrl_cnt = ctrl_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_wb_instret   = '0;
  assign o_wb_ctrl_cnt  = '0;
`endif

endmodule
